rmii_mac_rx_buf: RTL and testbench

Parametrised, buffered RMII receive MAC for 10/100 Ethernet. Strips preamble/SFD, packs received dibits LSB-first into DATA_WIDTH-bit words, buffers them in an internal FIFO and emits frames as an AXI stream. Frame status (overflow, alignment error, optional FCS error) is reported on the last beat's tuser. Sits between the RMII PHY pins and the packet-processing datapath.

---
 rtl/rmii_mac_rx_buf.sv | 169 ++++++++++++++++
 tb/tb_rmii_mac_rx_buf.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rmii_mac_rx_buf.sv
// rmii_mac_rx_buf: buffered RMII receive MAC to AXI stream; FCS check enabled by RMII_MAC_RX_BUF_FCS_CHECK_EN
module rmii_mac_rx_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int SYNC_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  arst_n,
    input  logic                  speed_10,
    input  logic [1:0]            rxd,
    input  logic                  crs_dv,
    output logic                  axi_tvalid,
    output logic [DATA_WIDTH-1:0] axi_tdata,
    output logic                  axi_tlast,
    output logic                  axi_tuser,
    input  logic                  axi_tready,
    output logic                  rx_overflow,
    output logic                  rx_fcs_err
);
    localparam int WD = DATA_WIDTH / 2;
    localparam int DW = WD > 1 ? $clog2(WD) : 1;
    localparam int AW = $clog2(WD > 4 ? WD : 4);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, PRE, DATA, FLUSH, DROP} state_t;
    state_t state, nstate;

    logic [SYNC_DEPTH-1:0][3:0] sy;
    logic                       valid, s_dv, dv_d, rise, stb, seen, take, full_word;
    logic [1:0]                 s_rxd;
    logic [3:0]                 cnt, cur;
    logic [DW-1:0]              dcnt;
    logic [AW-1:0]              acnt;
    logic [DATA_WIDTH-1:0]      asm_q, hold, word;
    logic                       hold_v, fcs_bad, err, push, plast, puser, pop, can_push;
    logic [DATA_WIDTH+1:0]      mem [FIFO_DEPTH];
    logic [DATA_WIDTH+1:0]      din, head;
    logic [PW-1:0]              wp, rp, rp_n;
    logic [PW:0]                fcnt, fcnt_n;

    // The top synchroniser bit marks stages refilled since reset, so a frame
    // already in progress at reset release never looks like a carrier edge.
    assign {valid, s_dv, s_rxd} = sy[SYNC_DEPTH-1];
    assign rise      = valid && s_dv && !dv_d;
    assign cur       = rise ? 4'd0 : cnt;
    assign stb       = !speed_10 || cur == 4'd4;
    assign take      = state == DATA && stb && s_dv;
    assign word      = DATA_WIDTH'({s_rxd, asm_q} >> 2);
    assign full_word = dcnt == DW'(WD - 1);
    assign err       = acnt != '0 || fcs_bad;

`ifdef RMII_MAC_RX_BUF_FCS_CHECK_EN
    logic [31:0] crc, crc_n;
    // Two reflected CRC-32 steps per dibit, bit 0 first
    always_comb begin
        crc_n = crc;
        for (int i = 0; i < 2; i++) crc_n = (crc_n[0] ^ s_rxd[i]) ? (crc_n >> 1) ^ 32'hEDB88320 : crc_n >> 1;
    end
    // CRC restarts during preamble and advances on every data dibit
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) crc <= '1;
        else if (state == PRE) crc <= '1;
        else if (take) crc <= crc_n;
    end
    assign fcs_bad    = crc != 32'hDEBB20E3;
    assign rx_fcs_err = state == FLUSH && nstate == IDLE && fcs_bad;
`else
    assign fcs_bad    = 1'b0;
    assign rx_fcs_err = 1'b0;
`endif

    // Next state and FIFO push requests
    always_comb begin
        nstate      = state;
        push        = 1'b0;
        plast       = 1'b0;
        puser       = 1'b0;
        rx_overflow = 1'b0;
        case (state)
            IDLE: nstate = rise ? PRE : IDLE;
            PRE: if (stb) nstate = !s_dv ? IDLE : (seen && s_rxd == 2'b11) ? DATA : PRE;
            DATA: begin
                if (stb && !s_dv) nstate = FLUSH;
                else if (take && full_word && hold_v) begin
                    push        = can_push;
                    rx_overflow = !can_push;
                    nstate      = can_push ? DATA : DROP;
                end
            end
            FLUSH: begin
                push   = hold_v && can_push;
                plast  = 1'b1;
                puser  = err;
                nstate = (!hold_v || can_push) ? IDLE : FLUSH;
            end
            DROP: begin
                push   = hold_v && can_push;
                plast  = 1'b1;
                puser  = 1'b1;
                nstate = ((!hold_v || can_push) && stb && !s_dv) ? IDLE : DROP;
            end
            default: nstate = IDLE;
        endcase
    end

    // Synchroniser, sample strobe counter, FSM state and word assembly
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            sy     <= '0;
            dv_d   <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
            seen   <= 1'b0;
            dcnt   <= '0;
            acnt   <= '0;
            asm_q  <= '0;
            hold   <= '0;
            hold_v <= 1'b0;
        end else begin
            sy    <= {sy[SYNC_DEPTH-2:0], 1'b1, crs_dv, rxd};
            dv_d  <= valid ? s_dv : 1'b1;
            cnt   <= cur == 4'd9 ? 4'd0 : cur + 4'd1;
            state <= nstate;
            seen  <= state == PRE && (seen || (stb && s_rxd == 2'b01));
            if (state == PRE) begin
                dcnt <= '0;
                acnt <= '0;
            end else if (take) begin
                asm_q <= word;
                dcnt  <= full_word ? '0 : dcnt + 1'b1;
                acnt  <= acnt + 1'b1;
            end
            if (take && full_word && !rx_overflow) begin
                hold   <= word;
                hold_v <= 1'b1;
            end else if (push && plast) hold_v <= 1'b0;
        end
    end

    // Head bypass covers a push landing in an otherwise empty FIFO
    assign pop      = axi_tvalid && axi_tready;
    assign can_push = fcnt != (PW+1)'(FIFO_DEPTH) || pop;
    assign rp_n     = rp + PW'(pop);
    assign fcnt_n   = fcnt + (PW+1)'(push) - (PW+1)'(pop);
    assign din      = {plast, puser, hold};
    assign head     = (push && wp == rp_n) ? din : mem[rp_n];

    // FIFO pointers and registered first-word-fall-through head
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            wp         <= '0;
            rp         <= '0;
            fcnt       <= '0;
            axi_tvalid <= 1'b0;
            {axi_tlast, axi_tuser, axi_tdata} <= '0;
        end else begin
            wp         <= wp + PW'(push);
            rp         <= rp_n;
            fcnt       <= fcnt_n;
            axi_tvalid <= fcnt_n != '0;
            if (fcnt_n != '0) {axi_tlast, axi_tuser, axi_tdata} <= head;
        end
    end

    // FIFO storage
    always_ff @(posedge clock) begin
        if (push) mem[wp] <= din;
    end
endmodule

// File: tb/tb_rmii_mac_rx_buf.sv
// tb_rmii_mac_rx_buf: randomized frames against a frame-level reference model
module tb_rmii_mac_rx_buf;
    localparam int W = 8;
    localparam int D = 16;
`ifdef RMII_MAC_RX_BUF_FCS_CHECK_EN
    localparam bit FCS = 1'b1;
`else
    localparam bit FCS = 1'b0;
`endif

    logic         clock = 1'b0, arst_n = 1'b0, speed_10 = 1'b0, crs_dv = 1'b0, axi_tready = 1'b0;
    logic [1:0]   rxd = 2'b00;
    logic         axi_tvalid, axi_tlast, axi_tuser, rx_overflow, rx_fcs_err;
    logic [W-1:0] axi_tdata;

    int           checks = 0, errors = 0, n_ovf = 0, n_fcs = 0, eo = 0, ef = 0;
    logic [9:0]   got[$], exp[$], prev = '0;
    logic [7:0]   fr[$];
    bit           pstall = 1'b0, rnd_rdy = 1'b0;
    int           n, x, idx;

    always #10 clock = ~clock;

    rmii_mac_rx_buf #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .SYNC_DEPTH(2)) dut (
        .clock(clock), .arst_n(arst_n), .speed_10(speed_10), .rxd(rxd), .crs_dv(crs_dv),
        .axi_tvalid(axi_tvalid), .axi_tdata(axi_tdata), .axi_tlast(axi_tlast), .axi_tuser(axi_tuser),
        .axi_tready(axi_tready), .rx_overflow(rx_overflow), .rx_fcs_err(rx_fcs_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, ex);
        end
    endtask

    // Beat capture, pulse counting and hold-under-backpressure check
    always @(negedge clock) begin
        if (axi_tvalid && axi_tready) got.push_back({axi_tlast, axi_tuser, axi_tdata});
        if (rx_overflow) n_ovf++;
        if (rx_fcs_err) n_fcs++;
        if (pstall && axi_tvalid) chk("stable", {axi_tlast, axi_tuser, axi_tdata}, prev);
        pstall = axi_tvalid && !axi_tready && arst_n;
        prev   = {axi_tlast, axi_tuser, axi_tdata};
    end

    initial forever begin
        @(posedge clock);
        #1;
        if (rnd_rdy) axi_tready = $urandom_range(0, 3) != 0;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] crc_of(input int len);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'd0, fr[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        return c;
    endfunction

    function automatic bit fcs_ok(input int len);
        return ~crc_of(len - 4) == {fr[len-1], fr[len-2], fr[len-3], fr[len-4]};
    endfunction

    task automatic make_frame(input int len);
        logic [31:0] c;
        fr.delete();
        for (int i = 0; i < len - 4; i++) fr.push_back(8'($urandom));
        c = ~crc_of(len - 4);
        for (int k = 0; k < 4; k++) fr.push_back(c[8*k+:8]);
    endtask

    // Frame-level model: every byte is a beat unless the buffer (cap words) overflows
    task automatic expect_frame(input int extra, input int cap);
        int len, m;
        bit bad, ovf;
        logic [9:0] e;
        len = fr.size();
        ovf = cap != 0 && len > cap;
        bad = extra != 0 || (FCS && !fcs_ok(len));
        m   = ovf ? cap : len;
        exp.delete();
        for (int i = 0; i < m; i++) begin
            e = {i == m - 1, i == m - 1 && (bad || ovf), fr[i]};
            exp.push_back(e);
        end
        eo = int'(ovf);
        ef = int'(FCS && bad && !ovf);
    endtask

    task automatic put(input logic [1:0] d);
        crs_dv = 1'b1;
        rxd    = d;
        repeat (speed_10 ? 10 : 1) @(posedge clock);
        #1;
    endtask

    task automatic send(input int extra, input int rst_at);
        logic [7:0] b;
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 4; k++) put((i == 7 && k == 3) ? 2'b11 : 2'b01);
        for (int i = 0; i < fr.size(); i++) begin
            b = fr[i];
            if (i == rst_at) arst_n = 1'b0;
            for (int k = 0; k < 4; k++) begin
                put(b[2*k+:2]);
                if (i == rst_at && k == 1) begin
                    chk("reset_mid", {axi_tvalid, axi_tlast, axi_tuser, axi_tdata, rx_overflow, rx_fcs_err}, 0);
                    arst_n = 1'b1;
                end
            end
        end
        for (int k = 0; k < extra; k++) put(2'($urandom));
        crs_dv = 1'b0;
        rxd    = 2'b00;
        repeat (40) @(posedge clock);
        #1;
    endtask

    task automatic finish_frame(input string tag);
        for (int t = 0; t < 3000 && got.size() < exp.size(); t++) @(posedge clock);
        repeat (20) @(posedge clock);
        #1;
        chk({tag, ".beats"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk($sformatf("%s.beat%0d", tag, i), got[i], exp[i]);
        chk({tag, ".ovf"}, n_ovf, eo);
        chk({tag, ".fcs"}, n_fcs, ef);
        got.delete();
        n_ovf = 0;
        n_fcs = 0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("reset", {axi_tvalid, axi_tlast, axi_tuser, axi_tdata, rx_overflow, rx_fcs_err}, 0);
        arst_n     = 1'b1;
        axi_tready = 1'b1;
        repeat (5) @(posedge clock);
        #1;

        make_frame(64);
        expect_frame(0, 0);
        send(0, -1);
        finish_frame("valid100");

        make_frame(64);
        idx = $urandom_range(0, 59);
        fr[idx] = fr[idx] ^ (8'd1 << $urandom_range(0, 7));
        expect_frame(0, 0);
        send(0, -1);
        finish_frame("fcsflip");

        speed_10 = 1'b1;
        make_frame(64);
        expect_frame(0, 0);
        send(0, -1);
        finish_frame("valid10");
        speed_10 = 1'b0;

        axi_tready = 1'b0;
        make_frame(64);
        expect_frame(0, D + 1);
        send(0, -1);
        axi_tready = 1'b1;
        finish_frame("overflow");

        make_frame(10);
        expect_frame(1, 0);
        send(1, -1);
        finish_frame("align");

        axi_tready = 1'b0;
        make_frame(30);
        send(0, 10);
        axi_tready = 1'b1;
        make_frame(64);
        expect_frame(0, 0);
        send(0, -1);
        finish_frame("after_reset");

        rnd_rdy = 1'b1;
        for (int f = 0; f < 6; f++) begin
            speed_10 = $urandom_range(0, 1) != 0;
            n = $urandom_range(8, 40);
            x = $urandom_range(0, 3);
            make_frame(n);
            expect_frame(x, 0);
            send(x, -1);
            finish_frame($sformatf("rand%0d", f));
        end
        rnd_rdy = 1'b0;
        axi_tready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
